// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and widths for the pipelined multiplier
package mult_pkg;

  localparam int ROB_IDX_W = 5;
  localparam int PRF_IDX_W = 6;
  localparam int BR_MASK_W = 4;
  localparam logic [PRF_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    MULL  = 2'b00,
    UMULH = 2'b01,
    MULH  = 2'b10
  } mult_op_e;

  function automatic int slice_w(input int xlen, input int stages);
    return xlen / stages;
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// rtl/mult_pipe_stage.sv - one partial-product stage with branch-mask squash and fix
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int SW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 rob_br_recovery_i,
  input  logic                 rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
  input  logic                 valid_i,
  input  mult_op_e             op_i,
  input  logic                 sign_fix_i,
  input  logic [2*XLEN-1:0]    acc_i,
  input  logic [2*XLEN-1:0]    mcand_i,
  input  logic [XLEN-1:0]      mplier_i,
  input  logic [ROB_IDX_W:0]   rob_idx_i,
  input  logic [PRF_IDX_W-1:0] dest_tag_i,
  input  logic [BR_MASK_W-1:0] br_mask_i,
  output logic                 valid_o,
  output mult_op_e             op_o,
  output logic                 sign_fix_o,
  output logic [2*XLEN-1:0]    acc_o,
  output logic [2*XLEN-1:0]    mcand_o,
  output logic [XLEN-1:0]      mplier_o,
  output logic [ROB_IDX_W:0]   rob_idx_o,
  output logic [PRF_IDX_W-1:0] dest_tag_o,
  output logic [BR_MASK_W-1:0] br_mask_o
);

  logic                 in_kill;
  logic                 self_kill;
  logic [BR_MASK_W-1:0] fix_clr;
  logic [2*XLEN-1:0]    partial;

  assign fix_clr   = rob_br_pred_correct_i ? rob_br_tag_fix_i : '0;
  assign in_kill   = rob_br_recovery_i && |(br_mask_i & rob_br_tag_fix_i);
  assign self_kill = rob_br_recovery_i && |(br_mask_o & rob_br_tag_fix_i);
  assign partial   = mcand_i * {{(2*XLEN-SW){1'b0}}, mplier_i[SW-1:0]};

  // An advancing stage overwrites its own squashed contents with the filtered incoming op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      op_o       <= MULL;
      sign_fix_o <= 1'b0;
      acc_o      <= '0;
      mcand_o    <= '0;
      mplier_o   <= '0;
      rob_idx_o  <= '0;
      dest_tag_o <= ZERO_REG;
      br_mask_o  <= '0;
    end else if (!stall_i) begin
      valid_o    <= valid_i && !in_kill;
      op_o       <= op_i;
      sign_fix_o <= sign_fix_i;
      acc_o      <= acc_i + partial;
      mcand_o    <= mcand_i << SW;
      mplier_o   <= mplier_i >> SW;
      rob_idx_o  <= rob_idx_i;
      dest_tag_o <= in_kill ? ZERO_REG : dest_tag_i;
      br_mask_o  <= br_mask_i & ~fix_clr;
    end else begin
      if (self_kill) begin
        valid_o    <= 1'b0;
        dest_tag_o <= ZERO_REG;
      end
      br_mask_o <= br_mask_o & ~fix_clr;
    end
  end

endmodule

// File: rtl/fu_mult_pipe.sv
// rtl/fu_mult_pipe.sv - parametrised pipelined multiplier FU with MULL/UMULH/MULH modes
module fu_mult_pipe
  import mult_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int NUM_STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [XLEN-1:0]      opa_i,
  input  logic [XLEN-1:0]      opb_i,
  input  logic [31:0]          inst_i,
  input  logic [1:0]           mult_op_i,
  input  logic [ROB_IDX_W:0]   rob_idx_i,
  input  logic [PRF_IDX_W-1:0] dest_tag_i,
  input  logic [BR_MASK_W-1:0] br_mask_i,
  input  logic                 rob_br_recovery_i,
  input  logic                 rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
  input  logic                 stall_i,
  output logic [XLEN-1:0]      result_o,
  output logic [ROB_IDX_W:0]   rob_idx_o,
  output logic [PRF_IDX_W-1:0] dest_tag_o,
  output logic [BR_MASK_W-1:0] br_mask_o,
  output logic                 done_pre_o,
  output logic                 done_o
);

  localparam int SW = slice_w(XLEN, NUM_STAGES);

  // Index 0 is the entry point; index s is the output of stage s.
  logic     [NUM_STAGES:0]                valid;
  mult_op_e [NUM_STAGES:0]                op;
  logic     [NUM_STAGES:0]                sign_fix;
  logic     [NUM_STAGES:0][2*XLEN-1:0]    acc;
  logic     [NUM_STAGES:0][2*XLEN-1:0]    mcand;
  logic     [NUM_STAGES:0][XLEN-1:0]      mplier;
  logic     [NUM_STAGES:0][ROB_IDX_W:0]   rob_idx;
  logic     [NUM_STAGES:0][PRF_IDX_W-1:0] dest_tag;
  logic     [NUM_STAGES:0][BR_MASK_W-1:0] br_mask;

  mult_op_e          entry_op;
  logic [XLEN-1:0]   mplier_sel;
  logic [2*XLEN-1:0] prod;
  logic              unused_ok;

  always_comb begin
    entry_op = MULL;
    case (mult_op_i)
      2'b01:   entry_op = UMULH;
      2'b10:   entry_op = MULH;
      default: entry_op = MULL;
    endcase
  end

  assign mplier_sel  = inst_i[12] ? XLEN'(inst_i[20:13]) : opb_i;

  assign valid[0]    = start_i;
  assign op[0]       = entry_op;
  assign sign_fix[0] = (entry_op == MULH) && mplier_sel[XLEN-1];
  assign acc[0]      = '0;
  assign mcand[0]    = (entry_op == MULH) ? {{XLEN{opa_i[XLEN-1]}}, opa_i}
                                          : {{XLEN{1'b0}}, opa_i};
  assign mplier[0]   = mplier_sel;
  assign rob_idx[0]  = rob_idx_i;
  assign dest_tag[0] = dest_tag_i;
  assign br_mask[0]  = br_mask_i;

  for (genvar s = 1; s <= NUM_STAGES; s++) begin : g_stage
    mult_pipe_stage #(
      .XLEN(XLEN),
      .SW  (SW)
    ) u_stage (
      .clk                  (clk),
      .rst_n                (rst_n),
      .stall_i              (stall_i),
      .rob_br_recovery_i    (rob_br_recovery_i),
      .rob_br_pred_correct_i(rob_br_pred_correct_i),
      .rob_br_tag_fix_i     (rob_br_tag_fix_i),
      .valid_i              (valid[s-1]),
      .op_i                 (op[s-1]),
      .sign_fix_i           (sign_fix[s-1]),
      .acc_i                (acc[s-1]),
      .mcand_i              (mcand[s-1]),
      .mplier_i             (mplier[s-1]),
      .rob_idx_i            (rob_idx[s-1]),
      .dest_tag_i           (dest_tag[s-1]),
      .br_mask_i            (br_mask[s-1]),
      .valid_o              (valid[s]),
      .op_o                 (op[s]),
      .sign_fix_o           (sign_fix[s]),
      .acc_o                (acc[s]),
      .mcand_o              (mcand[s]),
      .mplier_o             (mplier[s]),
      .rob_idx_o            (rob_idx[s]),
      .dest_tag_o           (dest_tag[s]),
      .br_mask_o            (br_mask[s])
    );
  end

  // After XLEN bits of shifting the carried multiplicand is exactly mcand_ext << XLEN.
  assign prod = acc[NUM_STAGES] -
                ((sign_fix[NUM_STAGES] && op[NUM_STAGES] == MULH) ? mcand[NUM_STAGES] : '0);

  assign result_o   = (op[NUM_STAGES] == MULL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign rob_idx_o  = rob_idx[NUM_STAGES];
  assign dest_tag_o = dest_tag[NUM_STAGES];
  assign br_mask_o  = br_mask[NUM_STAGES];
  assign done_o     = valid[NUM_STAGES];
  assign done_pre_o = valid[NUM_STAGES-1];

  assign unused_ok = ^{inst_i[31:21], inst_i[11:0], mplier[NUM_STAGES]};

endmodule
